arb_mux: RTL and testbench

Registered N-channel arbitrating multiplexer with valid/ready handshake, the multi-source successor to the team's 2:1 combinational select. It picks one of `CH` requesting channels per cycle, by fixed priority or round-robin, and presents the winner's word on a single registered output port with full backpressure. It sits between multiple result producers (ALU, load unit, multi-cycle units) and a single consumer such as the writeback path.

---
 rtl/arb_pkg.sv | 18 +
 rtl/arb_mux_if.sv | 39 +++
 rtl/arb_mux_rr_grant.sv | 59 +++++
 rtl/arb_mux.sv | 94 +++++++++
 tb/tb_arb_mux.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared constants and helpers for the arbitrating multiplexer (arb_mux)
// and its grant encoder (rr_grant).
//   MODE_FIXED : lowest-index requester always wins
//   MODE_RR    : round-robin starting at the priority pointer
//   idx_w()    : width of a channel index for a given channel count
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int idx_w(input int ch);
    return $clog2(ch);
  endfunction

endpackage

// File: rtl/arb_mux_if.sv
// ---------------------------------------------------------------------------
// arb_mux_if
// Bundles the CH request channels and the single registered output port of
// arb_mux.
//   in_data   : CH*n  channel i at [i*n +: n]
//   in_valid  : CH    per-channel request
//   in_ready  : CH    per-channel accept (one-hot or zero)
//   out_data  : n     registered winning word
//   out_valid : 1     out_data holds an unconsumed word
//   out_ready : 1     consumer accepts
//   out_sel   : SW    channel that produced out_data
// Modports: slave = arb_mux side, master = producers/consumer side.
// ---------------------------------------------------------------------------
interface arb_mux_if
  import arb_pkg::*;
#(
  parameter int n  = 32,
  parameter int CH = 4
);
  localparam int SW = idx_w(CH);

  logic [CH*n-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [CH-1:0]   in_ready;
  logic [n-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_sel;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/arb_mux_rr_grant.sv
// ---------------------------------------------------------------------------
// rr_grant
// Combinational round-robin grant encoder. Finds the first set request at or
// above ptr, wrapping from CH-1 back to 0.
//   req     : CH  request vector
//   ptr     : SW  search start index (tie to 0 for fixed priority)
//   gnt     : CH  one-hot grant, zero when no request
//   gnt_idx : SW  binary index of the granted channel (0 when none)
//   any     : 1   at least one request present
// The wrap is handled by a double-width vector {req, req & mask}: the low
// half holds requests at/above ptr, the high half all requests, so a plain
// lowest-bit search over both halves yields the wrapped winner.
// ---------------------------------------------------------------------------
module rr_grant
  import arb_pkg::*;
#(
  parameter int CH = 4,
  localparam int SW = idx_w(CH)
) (
  input  logic [CH-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic [CH-1:0] gnt,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);

  logic [CH-1:0]   mask;
  logic [2*CH-1:0] dbl;
  logic            found;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    mask    = '0;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    any     = |req;

    for (int i = 0; i < CH; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    dbl = {req, req & mask};

    for (int i = 0; i < 2*CH; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        if (i < CH) begin
          gnt[i]  = 1'b1;
          gnt_idx = SW'(i);
        end else begin
          gnt[i-CH] = 1'b1;
          gnt_idx   = SW'(i - CH);
        end
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// ---------------------------------------------------------------------------
// arb_mux
// Registered CH-channel arbitrating multiplexer with valid/ready handshake.
// One requesting channel per cycle is granted (fixed priority or
// round-robin) and its word is loaded into a single output register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : arb_mux_if.slave (request channels + registered output port)
// Parameters: n (data width), CH (channels), MODE (MODE_FIXED / MODE_RR).
// The output register accepts a new word when it is empty or being drained
// in the same cycle, giving one word per cycle under continuous demand.
// ---------------------------------------------------------------------------
module arb_mux
  import arb_pkg::*;
#(
  parameter int n    = 32,
  parameter int CH   = 4,
  parameter int MODE = MODE_RR,
  localparam int SW  = idx_w(CH)
) (
  input  logic        clk,
  input  logic        rst_n,
  arb_mux_if.slave    bus
);

  logic [n-1:0]  out_data_q,  out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_sel_q,   out_sel_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic [CH-1:0] gnt;
  logic [SW-1:0] gnt_idx;
  logic          any;
  logic          free;
  logic          xfer;
  logic [SW-1:0] search_ptr;

  // Fixed priority is round-robin with the search always starting at 0.
  assign search_ptr = (MODE == MODE_RR) ? ptr_q : '0;

  rr_grant #(.CH(CH)) u_grant (
    .req     (bus.in_valid),
    .ptr     (search_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign free = !out_valid_q || bus.out_ready;
  assign xfer = any && free;

  // Reset clears out_valid_q, which would make the register look free;
  // gating with rst_n keeps every channel un-accepted while in reset.
  assign bus.in_ready = (rst_n && free) ? gnt : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;

    if (xfer) begin
      out_data_d  = bus.in_data[int'(gnt_idx)*n +: n];
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      if (MODE == MODE_RR) begin
        ptr_d = (gnt_idx == SW'(CH-1)) ? '0 : gnt_idx + 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: flops are written with non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_arb_mux
// Drives a round-robin instance and a fixed-priority instance of arb_mux
// side by side and compares both against a behavioural model that picks the
// winner by scanning channels from the pointer with modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_arb_mux;
  import arb_pkg::*;

  localparam int N = 32;
  localparam int C = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arb_mux_if #(.n(N), .CH(C)) if_rr ();
  arb_mux_if #(.n(N), .CH(C)) if_fx ();

  arb_mux #(.n(N), .CH(C), .MODE(MODE_RR)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_rr)
  );

  arb_mux #(.n(N), .CH(C), .MODE(MODE_FIXED)) dut_fx (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_fx)
  );

  typedef struct {
    int           ptr;
    logic [N-1:0] data;
    logic         valid;
    int           sel;
  } model_t;

  model_t m_rr, m_fx;
  int total = 0;
  int bad   = 0;

  function automatic model_t model_reset();
    model_t m;
    m.ptr = 0; m.data = '0; m.valid = 1'b0; m.sel = 0;
    return m;
  endfunction

  // First requesting channel at or after p, wrapping.
  function automatic int pick(logic [C-1:0] v, int p);
    int c;
    for (int k = 0; k < C; k++) begin
      c = (p + k) % C;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [C-1:0] exp_ready(model_t m, logic [C-1:0] v, logic rdy, bit rr);
    int g;
    g = pick(v, rr ? m.ptr : 0);
    if (g < 0 || !(!m.valid || rdy)) return '0;
    return C'(1) << g;
  endfunction

  function automatic model_t advance(model_t m, logic [C-1:0] v, logic [C*N-1:0] d,
                                     logic rdy, bit rr);
    int g;
    g = pick(v, rr ? m.ptr : 0);
    if ((!m.valid || rdy) && g >= 0) begin
      m.data  = d[g*N +: N];
      m.sel   = g;
      m.valid = 1'b1;
      if (rr) m.ptr = (g + 1) % C;
    end else if (m.valid && rdy) begin
      m.valid = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [C*N-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_rr(input logic [C-1:0] v, input logic [C*N-1:0] d, input logic rdy);
    if_rr.in_valid  = v;
    if_rr.in_data   = d;
    if_rr.out_ready = rdy;
  endtask

  task automatic set_fx(input logic [C-1:0] v, input logic [C*N-1:0] d, input logic rdy);
    if_fx.in_valid  = v;
    if_fx.in_data   = d;
    if_fx.out_ready = rdy;
  endtask

  // One clock: check accept vectors, step the models, take the edge, then
  // check the registered outputs of both instances.
  task automatic tick();
    #1;
    check("rr_in_ready", if_rr.in_ready, exp_ready(m_rr, if_rr.in_valid, if_rr.out_ready, 1'b1));
    check("fx_in_ready", if_fx.in_ready, exp_ready(m_fx, if_fx.in_valid, if_fx.out_ready, 1'b0));
    m_rr = advance(m_rr, if_rr.in_valid, if_rr.in_data, if_rr.out_ready, 1'b1);
    m_fx = advance(m_fx, if_fx.in_valid, if_fx.in_data, if_fx.out_ready, 1'b0);
    @(posedge clk);
    #1;
    check("rr_out_valid", if_rr.out_valid, m_rr.valid);
    check("rr_out_data",  if_rr.out_data,  m_rr.data);
    check("rr_out_sel",   if_rr.out_sel,   m_rr.sel);
    check("rr_ptr",       dut_rr.ptr_q,    m_rr.ptr);
    check("fx_out_valid", if_fx.out_valid, m_fx.valid);
    check("fx_out_data",  if_fx.out_data,  m_fx.data);
    check("fx_out_sel",   if_fx.out_sel,   m_fx.sel);
    check("fx_ptr",       dut_fx.ptr_q,    m_fx.ptr);
  endtask

  initial begin
    logic [C*N-1:0] d;

    m_rr = model_reset();
    m_fx = model_reset();

    // Reset held with every channel requesting.
    set_rr('1, rand_data(), 1'b1);
    set_fx('1, rand_data(), 1'b1);
    #12;
    check("rst_in_ready",  if_rr.in_ready,  '0);
    check("rst_out_valid", if_rr.out_valid, 0);
    check("rst_out_data",  if_rr.out_data,  0);
    check("rst_out_sel",   if_rr.out_sel,   0);
    check("rst_ptr",       dut_rr.ptr_q,    0);
    check("rst_fx_ready",  if_fx.in_ready,  '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request on channel 2.
    d = rand_data();
    d[2*N +: N] = 32'hDEADBEEF;
    set_rr(4'b0100, d, 1'b1);
    set_fx('0, rand_data(), 1'b1);
    #1;
    check("single_ready", if_rr.in_ready, 4'b0100);
    tick();
    check("single_data",  if_rr.out_data,  32'hDEADBEEF);
    check("single_sel",   if_rr.out_sel,   2);
    check("single_valid", if_rr.out_valid, 1);
    check("single_ptr",   dut_rr.ptr_q,    3);

    // Grant channel 3 so the pointer wraps to 0 before the sweep.
    set_rr(4'b1000, rand_data(), 1'b1);
    tick();
    check("wrap_ptr", dut_rr.ptr_q, 0);

    // Round-robin sweep with all channels requesting.
    for (int k = 0; k < 8; k++) begin
      set_rr('1, rand_data(), 1'b1);
      tick();
      check("sweep_sel",   if_rr.out_sel,   k % C);
      check("sweep_valid", if_rr.out_valid, 1);
    end

    // Fixed priority: channel 0 always wins over 1 and 3.
    set_rr('0, rand_data(), 1'b1);
    for (int k = 0; k < 3; k++) begin
      set_fx(4'b1011, rand_data(), 1'b1);
      #1;
      check("fixed_ready", if_fx.in_ready, 4'b0001);
      tick();
      check("fixed_sel", if_fx.out_sel, 0);
    end
    set_fx('0, rand_data(), 1'b1);

    // Backpressure: load 0x11 from channel 1, then stall with all requesting.
    d = rand_data();
    d[1*N +: N] = 32'h00000011;
    set_rr(4'b0010, d, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_rr('1, rand_data(), 1'b0);
      #1;
      check("bp_ready", if_rr.in_ready, '0);
      tick();
      check("bp_data", if_rr.out_data, 32'h11);
      check("bp_sel",  if_rr.out_sel,  1);
      check("bp_ptr",  dut_rr.ptr_q,   2);
    end
    set_rr('1, rand_data(), 1'b1);
    #1;
    check("bp_release_ready", if_rr.in_ready, 4'b0100);
    tick();
    check("bp_release_sel", if_rr.out_sel, 2);

    // Reset mid-stream with a pending word and ptr = 3.
    set_rr('0, rand_data(), 1'b0);
    #2;
    check("pre_rst_valid", if_rr.out_valid, 1);
    check("pre_rst_ptr",   dut_rr.ptr_q,    3);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", if_rr.out_valid, 0);
    check("async_rst_ptr",   dut_rr.ptr_q,    0);
    check("async_rst_ready", if_rr.in_ready,  '0);
    m_rr = model_reset();
    m_fx = model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_rr('1, rand_data(), 1'b1);
    #1;
    check("post_rst_ready", if_rr.in_ready, 4'b0001);
    tick();
    check("post_rst_sel", if_rr.out_sel, 0);

    // Random traffic on both instances.
    for (int k = 0; k < 300; k++) begin
      set_rr(C'($urandom), rand_data(), ($urandom_range(0, 3) != 0));
      set_fx(C'($urandom), rand_data(), ($urandom_range(0, 3) != 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
